// File: rtl/wave_capture.sv
`default_nettype none
// ============================================================================
// Module   : wave_capture
// Summary  : Decimating sampler of the generator output into a FIFO that is
//            drained over the PicoSoC iomem bus, with a fill-level interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module wave_capture #(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] wave,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [3:0]  iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_DECIM  = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_DATA   = 2'd3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACK  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          pop_pend_q, pop_pend_d;
  logic          en_q, en_d;
  logic          oneshot_q, oneshot_d;
  logic [7:0]    thresh_q, thresh_d;
  logic [15:0]   decim_q, decim_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   dc_q, dc_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic          irq_q, irq_d;
  logic [31:0]   mem_q [DEPTH];

  logic [1:0]  reg_sel;
  logic [15:0] dc_last;
  logic        full, empty, wr_en, pop, clr, push_req, push_ok;
  logic [31:0] rd_mux;
  logic        unused_bits;

  assign reg_sel     = iomem_addr[3:2];
  assign unused_bits = ^{iomem_addr[1:0], iomem_wdata[31:16]};

  always_comb begin
    full     = (count_q == FULL_CNT);
    empty    = (count_q == '0);
    dc_last  = (decim_q == 16'd0) ? 16'd0 : decim_q - 16'd1;
    wr_en    = (state_q == ST_ACK) && (iomem_wstrb != 4'd0);
    pop      = (state_q == ST_ACK) && pop_pend_q;
    clr      = wr_en && (reg_sel == REG_CTRL) && iomem_wdata[2];
    push_req = en_q && (dc_q == dc_last) && !clr;
    push_ok  = push_req && (!full || pop);

    case (reg_sel)
      REG_CTRL:   rd_mux = {16'd0, thresh_q, 6'd0, oneshot_q, en_q};
      REG_DECIM:  rd_mux = {16'd0, decim_q};
      REG_STATUS: rd_mux = {21'd0, ovf_q, full, empty, 8'(count_q)};
      default:    rd_mux = empty ? 32'd0 : mem_q[rd_ptr_q];
    endcase
  end

  // Bus handshake: one-cycle ready, then hold off until valid is seen low.
  always_comb begin
    state_d    = state_q;
    rdata_d    = 32'd0;
    pop_pend_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (iomem_valid) begin
          state_d = ST_ACK;
          if (iomem_wstrb == 4'd0) begin
            rdata_d    = rd_mux;
            pop_pend_d = (reg_sel == REG_DATA) && !empty;
          end
        end
      end
      ST_ACK:  state_d = ST_WAIT;
      default: if (!iomem_valid) state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    en_d      = en_q;
    oneshot_d = oneshot_q;
    thresh_d  = thresh_q;
    decim_d   = decim_q;
    ovf_d     = ovf_q;
    if (wr_en) begin
      case (reg_sel)
        REG_CTRL: begin
          en_d      = iomem_wdata[0];
          oneshot_d = iomem_wdata[1];
          thresh_d  = iomem_wdata[15:8];
        end
        REG_DECIM:  decim_d = iomem_wdata[15:0];
        REG_STATUS: if (iomem_wdata[10]) ovf_d = 1'b0;
        default: ;
      endcase
    end

    if (clr) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ovf_d    = 1'b0;
    end else begin
      count_d  = count_q + CW'(push_ok) - CW'(pop);
      wr_ptr_d = wr_ptr_q + AW'(push_ok);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      if (push_req && full && !pop && !oneshot_q) ovf_d = 1'b1;
    end

    // One-shot capture stops on the push that fills the FIFO.
    if (push_ok && oneshot_q && (count_d == FULL_CNT)) en_d = 1'b0;

    dc_d  = (clr || !en_q || (dc_q >= dc_last)) ? 16'd0 : dc_q + 16'd1;
    irq_d = (thresh_q != 8'd0) && (8'(count_q) >= thresh_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rdata_q    <= 32'd0;
      pop_pend_q <= 1'b0;
      en_q       <= 1'b0;
      oneshot_q  <= 1'b0;
      thresh_q   <= 8'd0;
      decim_q    <= 16'd1;
      ovf_q      <= 1'b0;
      dc_q       <= 16'd0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rdata_q    <= rdata_d;
      pop_pend_q <= pop_pend_d;
      en_q       <= en_d;
      oneshot_q  <= oneshot_d;
      thresh_q   <= thresh_d;
      decim_q    <= decim_d;
      ovf_q      <= ovf_d;
      dc_q       <= dc_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      irq_q      <= irq_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wave;
  end

  assign iomem_ready = (state_q == ST_ACK);
  assign iomem_rdata = rdata_q;
  assign irq         = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_wave_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_wave_capture
// Summary  : Directed-sequence bench with random wave data and decimation;
//            expected FIFO contents are derived from the sample-time history.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wave_capture;

  localparam int DEPTH = 16;
  localparam int HN    = 8192;
  localparam logic [3:0] A_CTRL = 4'h0, A_DECIM = 4'h4, A_STATUS = 4'h8, A_DATA = 4'hC;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] wave = 32'd0;
  logic        iomem_valid = 1'b0;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb = 4'd0;
  logic [3:0]  iomem_addr = 4'd0;
  logic [31:0] iomem_wdata = 32'd0;
  logic [31:0] iomem_rdata;
  logic        irq;

  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  int          last_commit = 0;
  logic [31:0] hist [HN];
  logic [31:0] exp_q [$];
  bit          exp_ovf = 1'b0;

  wave_capture #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .wave(wave),
    .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
    .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr),
    .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // hist[e] is the wave value sampled by rising edge number e.
  initial forever begin
    @(negedge clk);
    wave = $urandom;
    hist[(cyc + 1) % HN] = wave;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion, expected finish before 20000 cycles");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus(input logic wr, input logic [3:0] a, input logic [31:0] wd,
                     output logic [31:0] rd);
    bit got = 1'b0;
    rd = 32'd0;
    @(negedge clk);
    iomem_valid = 1'b1;
    iomem_addr  = a;
    iomem_wstrb = wr ? 4'hF : 4'h0;
    iomem_wdata = wd;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      got = iomem_ready;
    end
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL bus_timeout: observed no ready, expected ready within 8 cycles");
    end else begin
      rd = iomem_rdata;
      @(posedge clk); #1;
      last_commit = cyc;
      chk("ready_single_cycle", 32'(iomem_ready), 32'd0);
    end
    iomem_valid = 1'b0;
    iomem_wstrb = 4'd0;
    @(posedge clk); #1;
  endtask

  task automatic wr_reg(input logic [3:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    bus(1'b1, a, d, dummy);
  endtask

  task automatic rd_reg(input logic [3:0] a, output logic [31:0] d);
    bus(1'b0, a, 32'd0, d);
  endtask

  task automatic wait_until(input int t);
    if (cyc > t) begin
      n_tests++;
      n_fail++;
      $display("FAIL schedule: observed cycle %0d, expected at most %0d", cyc, t);
    end
    while (cyc < t) begin
      @(posedge clk); #1;
    end
  endtask

  // Capture enabled at edge e, disabled at edge d: samples at e+n, e+2n, ... <= d.
  task automatic model_run(input int e, input int d, input int n, input bit os);
    for (int t = e + n; t <= d; t += n) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(hist[t % HN]);
      else if (!os) exp_ovf = 1'b1;
      if (os && exp_q.size() == DEPTH) break;
    end
  endtask

  function automatic logic [31:0] st_exp();
    logic [31:0] s;
    s     = 32'(exp_q.size());
    s[8]  = (exp_q.size() == 0);
    s[9]  = (exp_q.size() == DEPTH);
    s[10] = exp_ovf;
    return s;
  endfunction

  task automatic check_status(input string tag);
    logic [31:0] v;
    rd_reg(A_STATUS, v);
    chk(tag, v, st_exp());
  endtask

  task automatic drain(input string tag);
    logic [31:0] v;
    logic [31:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      rd_reg(A_DATA, v);
      chk(tag, v, e);
    end
  endtask

  initial begin
    logic [31:0] v;
    int e, d, n;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(iomem_ready), 32'd0);
    chk("rst_rdata", iomem_rdata, 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    rd_reg(A_CTRL, v);  chk("rst_ctrl", v, 32'd0);
    rd_reg(A_DECIM, v); chk("rst_decim", v, 32'd1);
    check_status("rst_status");

    // Basic capture with random decimation
    n = $urandom_range(2, 6);
    wr_reg(A_DECIM, 32'(n));
    wr_reg(A_CTRL, 32'h5);
    e = last_commit;
    wait_until(e + 4 * n + 1);
    wr_reg(A_CTRL, 32'h0);
    d = last_commit;
    model_run(e, d, n, 1'b0);
    check_status("basic_status");
    drain("basic_data");
    rd_reg(A_DATA, v); chk("basic_empty_read", v, 32'd0);
    check_status("basic_status_empty");

    // Continuous overflow
    wr_reg(A_DECIM, 32'd1);
    wr_reg(A_CTRL, 32'h5);
    e = last_commit;
    wait_until(e + 40);
    wr_reg(A_CTRL, 32'h0);
    model_run(e, last_commit, 1, 1'b0);
    check_status("ovf_status");
    drain("ovf_data");
    check_status("ovf_status_drained");
    wr_reg(A_STATUS, 32'h0);
    check_status("ovf_write_zero_keeps");

    // CLR coinciding with the 10th push (COUNT=9, OVF still set)
    n = $urandom_range(4, 7);
    wr_reg(A_DECIM, 32'(n));
    wr_reg(A_CTRL, 32'h1);
    e = last_commit;
    wait_until(e + 10 * n - 2);
    wr_reg(A_CTRL, 32'h4);
    chk("clr_commit_edge", 32'(last_commit), 32'(e + 10 * n));
    exp_q.delete();
    exp_ovf = 1'b0;
    check_status("clr_status");
    rd_reg(A_CTRL, v); chk("clr_ctrl", v, 32'd0);

    // OVF cleared by STATUS bit 10
    wr_reg(A_DECIM, 32'd1);
    wr_reg(A_CTRL, 32'h5);
    e = last_commit;
    wait_until(e + 20);
    wr_reg(A_CTRL, 32'h0);
    model_run(e, last_commit, 1, 1'b0);
    check_status("ovf2_status");
    wr_reg(A_STATUS, 32'h400);
    exp_ovf = 1'b0;
    check_status("ovf_cleared");
    wr_reg(A_CTRL, 32'h4);
    exp_q.delete();

    // One-shot
    wr_reg(A_DECIM, 32'd2);
    wr_reg(A_CTRL, 32'h7);
    e = last_commit;
    wait_until(e + 40);
    rd_reg(A_CTRL, v); chk("oneshot_en_cleared", v, 32'h2);
    model_run(e, e + 1000, 2, 1'b1);
    check_status("oneshot_status");
    drain("oneshot_data");

    // Threshold interrupt
    wr_reg(A_DECIM, 32'd1);
    wr_reg(A_CTRL, 32'h505);
    e = last_commit;
    wait_until(e + 5);
    chk("irq_not_yet", 32'(irq), 32'd0);
    wait_until(e + 6);
    chk("irq_rise", 32'(irq), 32'd1);
    wr_reg(A_CTRL, 32'h500);
    model_run(e, last_commit, 1, 1'b0);
    while (exp_q.size() > 5) begin
      logic [31:0] x;
      x = exp_q.pop_front();
      rd_reg(A_DATA, v); chk("irq_drain", v, x);
    end
    chk("irq_at_five", 32'(irq), 32'd1);
    begin
      logic [31:0] x;
      x = exp_q.pop_front();
      rd_reg(A_DATA, v); chk("irq_drain", v, x);
    end
    chk("irq_fall", 32'(irq), 32'd0);
    wr_reg(A_CTRL, 32'h200);
    chk("irq_thresh2", 32'(irq), 32'd1);
    wr_reg(A_CTRL, 32'h0);
    chk("irq_thresh0", 32'(irq), 32'd0);
    wr_reg(A_CTRL, 32'h4);
    exp_q.delete();

    // Simultaneous push/pop on a full FIFO
    n = $urandom_range(4, 7);
    wr_reg(A_DECIM, 32'(n));
    wr_reg(A_CTRL, 32'h5);
    e = last_commit;
    wait_until(e + 17 * n - 2);
    rd_reg(A_DATA, v);
    model_run(e, e + 16 * n, n, 1'b0);
    chk("pushpop_full_data", v, exp_q.pop_front());
    exp_q.push_back(hist[(e + 17 * n) % HN]);
    wr_reg(A_CTRL, 32'h0);
    check_status("pushpop_full_status");
    drain("pushpop_full_drain");

    // Simultaneous push/pop on an empty FIFO
    wr_reg(A_CTRL, 32'h5);
    e = last_commit;
    wait_until(e + n - 2);
    rd_reg(A_DATA, v);
    chk("pushpop_empty_data", v, 32'd0);
    wr_reg(A_CTRL, 32'h0);
    exp_q.push_back(hist[(e + n) % HN]);
    check_status("pushpop_empty_status");

    // Reset while a read is pending
    wr_reg(A_CTRL, 32'h100);
    chk("pre_reset_irq", 32'(irq), 32'd1);
    @(negedge clk);
    iomem_valid = 1'b1;
    iomem_addr  = A_DATA;
    iomem_wstrb = 4'd0;
    reset       = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("mid_rst_ready", 32'(iomem_ready), 32'd0);
      chk("mid_rst_rdata", iomem_rdata, 32'd0);
      chk("mid_rst_irq", 32'(irq), 32'd0);
    end
    @(negedge clk);
    reset       = 1'b0;
    iomem_valid = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ready", 32'(iomem_ready), 32'd0);
    exp_q.delete();
    exp_ovf = 1'b0;
    rd_reg(A_CTRL, v);  chk("post_rst_ctrl", v, 32'd0);
    rd_reg(A_DECIM, v); chk("post_rst_decim", v, 32'd1);
    check_status("post_rst_status");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
